motion_mask_gen: RTL

// - Downstream consumer of the sigma-delta background/variance update stage.
// - Takes each pixel with its updated background and variance and produces a
//   1-bit motion mask: motion = |curr - background| > max(variance, VAR_MIN).
// - Streams the mask through a 2-stage valid/ready pipeline with raster

---
 rtl/motion_mask_gen_if.sv | 36 +++
 rtl/motion_mask_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/motion_mask_gen_if.sv
// motion_mask_gen_if
//   Stream bundle for the motion-mask stage: the pixel input channel
//   (curr/background/variance beat with valid/ready) and the mask output
//   channel (mask bit plus raster tags with valid/ready).
//   Handshake rule for both channels: a beat transfers on a rising clock edge
//   where valid & ready are both high; once valid is raised, the producer
//   holds the beat stable until it transfers; ready may be asserted
//   independently of valid.
// Modports
//   slave  : the mask generator (consumes pixels, produces mask beats)
//   master : the environment (produces pixels, consumes mask beats)
interface motion_mask_gen_if;
  // pixel input channel
  logic       in_valid;
  logic       in_ready;
  logic [7:0] curr_pixel;
  logic [7:0] background_next;
  logic [7:0] variance_next;
  // mask output channel
  logic       out_valid;
  logic       out_ready;
  logic       mask_bit;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;

  modport slave (
    input  in_valid, curr_pixel, background_next, variance_next, out_ready,
    output in_ready, out_valid, mask_bit, out_sof, out_eol, out_eof
  );

  modport master (
    output in_valid, curr_pixel, background_next, variance_next, out_ready,
    input  in_ready, out_valid, mask_bit, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/motion_mask_gen.sv
// motion_mask_gen
//   Turns each pixel (with the background and variance from the sigma-delta
//   update stage) into a 1-bit motion mask:
//     motion = |curr - background| > max(variance, VAR_MIN)
//   The mask travels through a 2-stage valid/ready pipeline carrying raster
//   position tags (sof/eol/eof), and the number of motion pixels in each
//   complete frame is reported.
// Ports
//   clk              : clock, rising edge
//   rst              : asynchronous reset, active low
//   resync           : next accepted pixel is frame pixel (0,0); aborts the
//                      frame currently being counted
//   bus              : pixel input and mask output channels (slave side)
//   frame_done       : 1-cycle pulse after the eof beat has handshaken
//   frame_motion_cnt : motion-pixel count of the last completed frame
//   fsm_state        : frame-tracking state (0 idle, 1 run, 2 done)
module motion_mask_gen #(
  parameter  int IMG_W   = 320,
  parameter  int IMG_H   = 240,
  parameter  int VAR_MIN = 2,
  localparam int CNT_W   = $clog2(IMG_W * IMG_H + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 resync,
  motion_mask_gen_if.slave     bus,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     frame_motion_cnt,
  output logic [1:0]           fsm_state
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0]    X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    Y_LAST   = YW'(IMG_H - 1);
  localparam logic [7:0]       VAR_FLR  = 8'(VAR_MIN);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IMG_W * IMG_H);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;

  // raster position of the next pixel to be accepted
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;

  // stage 1: difference and threshold
  logic       s1_valid;
  logic [7:0] s1_diff;
  logic [7:0] s1_thr;
  logic       s1_sof, s1_eol, s1_eof;

  // stage 2: mask beat presented downstream
  logic       s2_valid;
  logic       s2_mask;
  logic       s2_sof, s2_eol, s2_eof;

  logic [CNT_W-1:0] acc;

  logic             adv, accept, out_fire;
  logic [XW-1:0]    tag_x;
  logic [YW-1:0]    tag_y;
  logic             tag_sof, tag_eol, tag_eof;
  logic [7:0]       in_diff, in_thr;
  logic [CNT_W-1:0] acc_plus, mask_cnt;

  // Both stages move together whenever the output stage is empty or draining,
  // so a stall freezes S1 and S2 as a unit and nothing is lost or repeated.
  // in_ready is forced low while reset is asserted.
  assign adv          = !s2_valid || bus.out_ready;
  assign bus.in_ready = adv && rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_fire     = s2_valid && bus.out_ready;

  // resync coinciding with an accept tags that beat as (0,0)
  assign tag_x   = resync ? '0 : pos_x;
  assign tag_y   = resync ? '0 : pos_y;
  assign tag_sof = (tag_x == '0) && (tag_y == '0);
  assign tag_eol = (tag_x == X_LAST);
  assign tag_eof = tag_eol && (tag_y == Y_LAST);

  // absolute difference without wrap, threshold floored at VAR_MIN
  assign in_diff = (bus.curr_pixel >= bus.background_next) ?
                   (bus.curr_pixel - bus.background_next) :
                   (bus.background_next - bus.curr_pixel);
  assign in_thr  = (bus.variance_next > VAR_FLR) ? bus.variance_next : VAR_FLR;

  assign mask_cnt = CNT_W'(s2_mask);
  assign acc_plus = (acc == CNT_MAX) ? acc : (acc + mask_cnt);

  assign bus.out_valid = s2_valid;
  assign bus.mask_bit  = s2_mask;
  assign bus.out_sof   = s2_sof;
  assign bus.out_eol   = s2_eol;
  assign bus.out_eof   = s2_eof;
  assign fsm_state     = state;

  // raster position counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (accept) begin
      if (tag_eol) begin
        pos_x <= '0;
        pos_y <= (tag_y == Y_LAST) ? '0 : (tag_y + YW'(1));
      end else begin
        pos_x <= tag_x + XW'(1);
        pos_y <= tag_y;
      end
    end else if (resync) begin
      pos_x <= '0;
      pos_y <= '0;
    end
  end

  // two-stage pipeline; empty stages carry all-zero payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_thr   <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
      s2_valid <= 1'b0;
      s2_mask  <= 1'b0;
      s2_sof   <= 1'b0;
      s2_eol   <= 1'b0;
      s2_eof   <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
      s1_diff  <= accept ? in_diff : '0;
      s1_thr   <= accept ? in_thr  : '0;
      s1_sof   <= accept && tag_sof;
      s1_eol   <= accept && tag_eol;
      s1_eof   <= accept && tag_eof;
      s2_valid <= s1_valid;
      s2_mask  <= s1_valid && (s1_diff > s1_thr);
      s2_sof   <= s1_sof;
      s2_eol   <= s1_eol;
      s2_eof   <= s1_eof;
    end
  end

  // Frame tracking and motion accumulation on the output handshake.
  // Counting only starts at an sof beat, so a stream picked up mid-frame is
  // passed through but never reported as a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      acc              <= '0;
      frame_motion_cnt <= '0;
      frame_done       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (resync) begin
        state <= ST_IDLE;
        acc   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (out_fire && s2_sof) begin
              state <= ST_RUN;
              acc   <= mask_cnt;
            end
          end
          ST_RUN: begin
            if (out_fire) begin
              if (s2_eof) begin
                frame_motion_cnt <= acc_plus;
                acc              <= '0;
                state            <= ST_DONE;
                frame_done       <= 1'b1;
              end else if (s2_sof) begin
                // a new frame started without an eof: restart the count
                acc <= mask_cnt;
              end else begin
                acc <= acc_plus;
              end
            end
          end
          ST_DONE: begin
            if (out_fire && s2_sof) begin
              state <= ST_RUN;
              acc   <= mask_cnt;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
            acc   <= '0;
          end
        endcase
      end
    end
  end

endmodule
